// File: rtl/ifns_decoder_33.sv
// Three-stage decoder from a 33-wire Fibonacci-weighted IFNS codeword to 23-bit data.
// Words whose weighted sum overflows 23 bits are flagged and counted.
module ifns_decoder_33 #(
  parameter int CODE_W = 33,
  parameter int DATA_W = 23,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] codein,
  output logic              data_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              code_err,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              err_cnt_clr
);

  localparam int SUM_W = DATA_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              s0_valid;
  logic [CODE_W-1:0] s0_code;
  logic              s1_valid;
  logic [SUM_W-1:0]  s1_lo, s1_mid, s1_hi;
  logic [SUM_W-1:0]  part_lo, part_mid, part_hi;
  logic [SUM_W-1:0]  fib_cur, fib_prev, fib_next;
  logic [SUM_W-1:0]  sum;
  logic              err_event;

  // Weights are generated by the Fibonacci recurrence and fold to constants.
  always_comb begin
    part_lo  = '0;
    part_mid = '0;
    part_hi  = '0;
    fib_cur  = SUM_W'(1);
    fib_prev = '0;
    fib_next = '0;
    for (int k = 1; k <= CODE_W; k++) begin
      if (s0_code[k-1]) begin
        if (k <= 11)
          part_lo = part_lo + fib_cur;
        else if (k <= 22)
          part_mid = part_mid + fib_cur;
        else
          part_hi = part_hi + fib_cur;
      end
      fib_next = fib_cur + fib_prev;
      fib_prev = fib_cur;
      fib_cur  = fib_next;
    end
  end

  assign sum       = s1_lo + s1_mid + s1_hi;
  assign err_event = s1_valid & sum[DATA_W];

  always_ff @(posedge clock) begin
    if (rst) begin
      s0_valid   <= 1'b0;
      s0_code    <= '0;
      s1_valid   <= 1'b0;
      s1_lo      <= '0;
      s1_mid     <= '0;
      s1_hi      <= '0;
      data_valid <= 1'b0;
      dataout    <= '0;
      code_err   <= 1'b0;
    end else begin
      s0_valid   <= code_valid;
      s0_code    <= codein;
      s1_valid   <= s0_valid;
      s1_lo      <= part_lo;
      s1_mid     <= part_mid;
      s1_hi      <= part_hi;
      data_valid <= s1_valid;
      code_err   <= err_event;
      if (s1_valid)
        dataout <= sum[DATA_W-1:0];
    end
  end

  // A clear that coincides with an error keeps that error counted.
  always_ff @(posedge clock) begin
    if (rst)
      err_cnt <= '0;
    else if (err_cnt_clr)
      err_cnt <= err_event ? CNT_W'(1) : '0;
    else if (err_event && err_cnt != CNT_MAX)
      err_cnt <= err_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ifns_decoder_33.sv
// Randomised scoreboard bench for ifns_decoder_33; expected words come from a
// Fibonacci-weight sum model and are checked by an independent monitor.
module tb_ifns_decoder_33;

  localparam int CNT_W = 4;
  localparam logic [32:0] ALL_ONES = {33{1'b1}};

  typedef struct {
    logic [22:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic              clock = 1'b0;
  logic              rst = 1'b1;
  logic              code_valid = 1'b0;
  logic [32:0]       codein = '0;
  logic              err_cnt_clr = 1'b0;
  logic              data_valid;
  logic [22:0]       dataout;
  logic              code_err;
  logic [CNT_W-1:0]  err_cnt;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          fibw[1:33];
  logic        rst_s = 1'b1;
  logic        clr_s = 1'b0;
  int          cnt_model = 0;
  logic [22:0] last_data = '0;

  ifns_decoder_33 #(.CODE_W(33), .DATA_W(23), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .rst         (rst),
    .code_valid  (code_valid),
    .codein      (codein),
    .data_valid  (data_valid),
    .dataout     (dataout),
    .code_err    (code_err),
    .err_cnt     (err_cnt),
    .err_cnt_clr (err_cnt_clr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc   = cyc + 1;
    rst_s = rst;
    clr_s = err_cnt_clr;
  end

  function automatic int model_sum(input logic [32:0] c);
    int s = 0;
    for (int k = 1; k <= 33; k++)
      if (c[k-1]) s += fibw[k];
    return s;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Inputs change 1 time unit after an edge and are sampled on the next one.
  task automatic apply_stimulus(input logic v, input logic [32:0] c, input logic clr, input logic r);
    exp_t e;
    int   s;
    @(posedge clock);
    #1;
    code_valid  = v;
    codein      = c;
    err_cnt_clr = clr;
    rst         = r;
    if (r) begin
      while (sb.size() > 0 && sb[$].due > cyc)
        void'(sb.pop_back());
    end else if (v) begin
      s      = model_sum(c);
      e.data = 23'(s);
      e.err  = (s > 8388607);
      e.due  = cyc + 3;
      sb.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    logic exp_v;
    logic ev;
    exp_v = 1'b0;
    ev    = 1'b0;
    if (rst_s) begin
      cnt_model = 0;
      last_data = '0;
      check_output("reset_valid", 32'(data_valid), 32'd0);
      check_output("reset_data", 32'(dataout), 32'd0);
      check_output("reset_err", 32'(code_err), 32'd0);
    end else begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e     = sb.pop_front();
        exp_v = 1'b1;
        ev    = e.err;
      end
      check_output("data_valid", 32'(data_valid), 32'(exp_v));
      if (exp_v) begin
        check_output("dataout", 32'(dataout), 32'(e.data));
        check_output("code_err", 32'(code_err), 32'(e.err));
        last_data = e.data;
      end else begin
        check_output("idle_err", 32'(code_err), 32'd0);
        check_output("hold_data", 32'(dataout), 32'(last_data));
      end
      if (clr_s && ev)
        cnt_model = 1;
      else if (clr_s)
        cnt_model = 0;
      else if (ev && cnt_model < (2**CNT_W - 1))
        cnt_model++;
    end
    check_output("err_cnt", 32'(err_cnt), 32'(cnt_model));
  end

  initial begin
    logic [32:0] rc;
    fibw[1] = 1;
    fibw[2] = 1;
    for (int k = 3; k <= 33; k++)
      fibw[k] = fibw[k-1] + fibw[k-2];

    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);

    // Zero word, then sparse words back to back.
    apply_stimulus(1'b1, 33'h0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 33'h1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 33'h2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 33'h14, 1'b0, 1'b0);
    apply_stimulus(1'b1, 33'h1_0000_0000, 1'b0, 1'b0);
    apply_stimulus(1'b1, ALL_ONES, 1'b0, 1'b0);
    apply_stimulus(1'b1, 33'h155, 1'b0, 1'b0);

    // Gapped stream with garbage on codein during the gaps.
    apply_stimulus(1'b1, 33'h0_0000_1234, 1'b0, 1'b0);
    apply_stimulus(1'b0, ALL_ONES, 1'b0, 1'b0);
    apply_stimulus(1'b0, ALL_ONES, 1'b0, 1'b0);
    apply_stimulus(1'b1, 33'h0_0040_0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);

    // Saturate the narrow counter, then clear on an error edge and alone.
    for (int i = 0; i < 20; i++)
      apply_stimulus(1'b1, ALL_ONES, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b1, ALL_ONES, 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);

    // Reset while words are in flight, then resume.
    apply_stimulus(1'b1, ALL_ONES, 1'b0, 1'b0);
    apply_stimulus(1'b1, 33'h0_00FF_00FF, 1'b0, 1'b0);
    apply_stimulus(1'b1, 33'h1_2345_6789, 1'b0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 33'h0_0000_0808, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      rc = {$urandom_range(1, 0) == 1, $urandom()};
      if ($urandom_range(9, 0) < 2)
        rc = rc | ALL_ONES;
      apply_stimulus($urandom_range(9, 0) < 7, rc, $urandom_range(19, 0) == 0, 1'b0);
    end

    for (int i = 0; i < 6; i++)
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifns_decoder_33.md
Name: ifns_decoder_33

Overview:
Receive-side counterpart of the 33-wire IFNS crosstalk-avoidance encoder. It converts a 33-bit Fibonacci-weighted codeword back to the original 23-bit data word.
- Fully pipelined streaming decoder: one codeword per clock, fixed latency.
- Flags codewords whose weighted value exceeds the 23-bit data range.
- Keeps a saturating count of out-of-range codewords.
- Sits at the bus receiver, directly after the wire sampling flops.

Parameters:
CODE_W, 33, codeword width (bit k, 1-based, has weight F(k)); only 33 is supported.
DATA_W, 23, decoded data width; only 23 is supported.
CNT_W, 16, width of the saturating error counter; any value 2..32 is legal.

Ports:
clock  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
code_valid  in  1  codein is valid this cycle
codein  in  33  received codeword; bit index k-1 carries code bit d(k)
data_valid  out  1  dataout and code_err are valid
dataout  out  23  decoded data word
code_err  out  1  decoded sum exceeded 2^23-1
err_cnt  out  CNT_W  saturating count of code_err events
err_cnt_clr  in  1  synchronous clear of err_cnt

Behaviour:
- Reset is synchronous: all outputs are sampled on a rising edge with rst=1.
- Reset values: data_valid=0, dataout=0, code_err=0, err_cnt=0. All pipeline valid bits are cleared and pipeline data registers are zeroed.
- Weights: F(1)=1, F(2)=1, F(k)=F(k-1)+F(k-2). So d33 has weight 3524578.
- The maximum possible sum is 9227464, so the sum needs 24 bits internally.
- Decoded value is S = sum over k of d(k)*F(k).
- Stage 0 (edge N): register code_valid and codein.
- Stage 1 (edge N+1): compute three 24-bit partial sums over bits 1-11, 12-22 and 23-33, and register them with valid.
- Stage 2 (edge N+2): add the partial sums to form S.
  - dataout <= S[22:0].
  - code_err <= S[23] (S > 8388607).
  - data_valid <= stage-1 valid.
- Latency: code_valid sampled at edge N gives data_valid high in the cycle following edge N+2, i.e. 3 cycles.
- Throughput: 1 codeword per cycle. There is no backpressure; every accepted word emerges exactly once, in order.
- When stage-1 valid is 0:
  - data_valid <= 0.
  - dataout holds its last value.
  - code_err <= 0.
- The constraint legality of the codeword pattern is not checked; only range is checked.
- err_cnt update priority, per edge:
  - If err_cnt_clr=1 and a code_err event is being produced this edge, err_cnt <= 1.
  - Else if err_cnt_clr=1, err_cnt <= 0.
  - Else if an event occurs and err_cnt < 2^CNT_W-1, err_cnt increments by 1.
  - At 2^CNT_W-1 it holds (saturates; never wraps).
  - An event means stage-2 is loading code_err=1 with data_valid=1.
- Reset mid-stream: every word in flight is discarded. data_valid stays 0 until 3 cycles after the first code_valid accepted after reset deassertion.
- code_valid=0 with arbitrary codein must not create a data_valid pulse or an err_cnt change.
- There are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then codein=0 with code_valid=1 -> 3 cycles later data_valid=1, dataout=0, code_err=0.
2. Single-bit and sparse words: d1 only -> 1; d2 only -> 1; d3+d5 -> 7; d33 only -> 3524578. Send back-to-back on consecutive cycles -> outputs appear on consecutive cycles in the same order, each 3 cycles after its input.
3. All-ones codeword -> dataout=838856 (9227464-2^23), code_err=1, err_cnt=1. A following valid word with S<2^23 -> code_err=0, err_cnt stays 1.
4. Gapped stream: pattern valid,0,0,valid -> data_valid pattern 1,0,0,1 after 3 cycles. dataout holds during the gap; err_cnt is unchanged by the invalid cycles.
5. CNT_W=4: drive 20 all-ones words -> err_cnt saturates at 15. Then err_cnt_clr coincident with an error event -> err_cnt=1. Then err_cnt_clr alone -> err_cnt=0.
6. Assert rst for 1 cycle while 3 words are in flight -> none is output. All outputs read 0 the cycle after the reset edge. The next accepted word decodes correctly at latency 3.
